// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match controller.
//   match_state_t : match sequencer states
//   SERVE_LEFT / SERVE_RIGHT : serve_dir encodings
//   FRAME_CNT_W   : width of the frame counter
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    POINT     = 3'd4,
    CHECK     = 3'd5,
    GAME_OVER = 3'd6
  } match_state_t;

  localparam logic SERVE_LEFT  = 1'b0;
  localparam logic SERVE_RIGHT = 1'b1;

  localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioning: 2-FF synchroniser followed by a rising-edge detector.
// No debounce is performed here.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   btn_i   : raw asynchronous button level
//   pulse_o : one-cycle pulse on each synchronised rising edge
module btn_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match-level sequencer for Pong. Converts ball out-of-bounds levels into
// single-cycle score pulses, times serve delays in frames, clears the score
// board at match start and detects match end from the score board win flags.
// All outputs are registered.
// Ports:
//   pixel_clk, rst_n              : clock, asynchronous active-low reset
//   fsync                         : one-cycle frame-start pulse
//   start_btn, pause_btn          : raw asynchronous buttons
//   ball_out_left, ball_out_right : ball has left the field (levels)
//   player_1_win, player_2_win    : win flags from score_board
//   player_1_scored, player_2_scored : one-cycle score pulses to score_board
//   score_clr                     : clear to score_board
//   ball_hold, serve_dir, paddles_en : datapath controls
//   game_over, winner             : match result (winner valid with game_over)
//   dbg_state                     : current sequencer state (debug)
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned OVER_FRAMES  = 180
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       fsync,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       ball_out_left,
  input  logic       ball_out_right,
  input  logic       player_1_win,
  input  logic       player_2_win,
  output logic       player_1_scored,
  output logic       player_2_scored,
  output logic       score_clr,
  output logic       ball_hold,
  output logic       serve_dir,
  output logic       paddles_en,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] dbg_state
);

  localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] OVER_LAST  = FRAME_CNT_W'(OVER_FRAMES - 1);

  logic start_p;
  logic pause_p;

  btn_sync_edge u_start_sync (
    .clk_i   (pixel_clk),
    .rst_ni  (rst_n),
    .btn_i   (start_btn),
    .pulse_o (start_p)
  );

  btn_sync_edge u_pause_sync (
    .clk_i   (pixel_clk),
    .rst_ni  (rst_n),
    .btn_i   (pause_btn),
    .pulse_o (pause_p)
  );

  match_state_t           state_q, state_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  // Set when leaving GAME_OVER so IDLE lasts one cycle and then serves
  // without waiting for another start press.
  logic                   rearm_q, rearm_d;
  logic                   p1_scored_q, p1_scored_d;
  logic                   p2_scored_q, p2_scored_d;
  logic                   score_clr_q, score_clr_d;
  logic                   ball_hold_q, ball_hold_d;
  logic                   serve_dir_q, serve_dir_d;
  logic                   paddles_en_q, paddles_en_d;
  logic                   game_over_q, game_over_d;
  logic                   winner_q, winner_d;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      rearm_q      <= 1'b0;
      p1_scored_q  <= 1'b0;
      p2_scored_q  <= 1'b0;
      score_clr_q  <= 1'b1;
      ball_hold_q  <= 1'b1;
      serve_dir_q  <= SERVE_LEFT;
      paddles_en_q <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      rearm_q      <= rearm_d;
      p1_scored_q  <= p1_scored_d;
      p2_scored_q  <= p2_scored_d;
      score_clr_q  <= score_clr_d;
      ball_hold_q  <= ball_hold_d;
      serve_dir_q  <= serve_dir_d;
      paddles_en_q <= paddles_en_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    rearm_d     = rearm_q;
    p1_scored_d = 1'b0;
    p2_scored_d = 1'b0;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;

    case (state_q)
      IDLE: begin
        if (start_p || rearm_q) begin
          state_d     = SERVE;
          serve_dir_d = SERVE_LEFT;
          rearm_d     = 1'b0;
        end
      end

      SERVE: begin
        if (fsync) begin
          if (frame_cnt_q == SERVE_LAST) begin
            state_d = PLAY;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

      PLAY: begin
        // Simultaneous exits are a let: re-serve in the same direction.
        if (ball_out_left && ball_out_right) begin
          state_d = SERVE;
        end else if (ball_out_left) begin
          p1_scored_d = 1'b1;
          serve_dir_d = SERVE_LEFT;
          state_d     = POINT;
        end else if (ball_out_right) begin
          p2_scored_d = 1'b1;
          serve_dir_d = SERVE_RIGHT;
          state_d     = POINT;
        end else if (pause_p) begin
          state_d = PAUSE;
        end
      end

      POINT: begin
        state_d = CHECK;
      end

      // Score board has registered the point by now, so win flags are current.
      CHECK: begin
        if (player_1_win) begin
          state_d  = GAME_OVER;
          winner_d = 1'b0;
        end else if (player_2_win) begin
          state_d  = GAME_OVER;
          winner_d = 1'b1;
        end else begin
          state_d = SERVE;
        end
      end

      PAUSE: begin
        if (pause_p) begin
          state_d = PLAY;
        end
      end

      GAME_OVER: begin
        if (fsync && (frame_cnt_q != OVER_LAST)) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
        if (start_p && (frame_cnt_q == OVER_LAST)) begin
          state_d = IDLE;
          rearm_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      frame_cnt_d = '0;
    end

    // Outputs are registered from the next state so they line up with it.
    score_clr_d  = (state_d == IDLE);
    ball_hold_d  = (state_d != PLAY);
    paddles_en_d = (state_d == SERVE) || (state_d == PLAY) ||
                   (state_d == POINT) || (state_d == CHECK);
    game_over_d  = (state_d == GAME_OVER);
  end

  assign player_1_scored = p1_scored_q;
  assign player_2_scored = p2_scored_q;
  assign score_clr       = score_clr_q;
  assign ball_hold       = ball_hold_q;
  assign serve_dir       = serve_dir_q;
  assign paddles_en      = paddles_en_q;
  assign game_over       = game_over_q;
  assign winner          = winner_q;
  assign dbg_state       = state_q;

endmodule
